// File: rtl/instr_loader.sv
// Instruction loader: assembles 16-bit words from byte strobes, queues them in
// a 4-entry FIFO and issues them to the CPU with a load/start/wait handshake.
module instr_loader (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [7:0]  byte_in,
    input  logic        hi_sel,
    input  logic        byte_valid,
    input  logic        clr_err,
    input  logic        w,
    output logic [15:0] instr_out,
    output logic        load,
    output logic        s,
    output logic        busy,
    output logic [2:0]  fifo_cnt,
    output logic        err_seq,
    output logic        err_ovf,
    output logic [7:0]  exec_cnt
);

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t state, next_state;

    logic [7:0]        hi_reg;
    logic              hi_pend;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt;

    logic push_req, seq_evt, pop, full, push_ok, ovf_evt, exec_inc;
    logic load_d, s_d, busy_d;

    // Byte-strobe decode and FIFO push/pop qualification.
    always_comb begin
        push_req = byte_valid && !hi_sel && hi_pend;
        seq_evt  = byte_valid && !hi_sel && !hi_pend;
        pop      = (state == LOAD);
        full     = (cnt == CNT_W'(DEPTH));
        // A full queue still accepts a word when the head leaves the same cycle;
        // the head has already been captured into instr_out on entry to LOAD.
        push_ok  = push_req && (!full || pop);
        ovf_evt  = push_req && full && !pop;
        exec_inc = (state == WAIT_HI) && w;
    end

    // High-byte holding register, independent of the issue FSM.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hi_reg  <= '0;
            hi_pend <= 1'b0;
        end else if (byte_valid && hi_sel) begin
            hi_reg  <= byte_in;
            hi_pend <= 1'b1;
        end else if (push_req) begin
            hi_pend <= 1'b0;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {hi_reg, byte_in};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error flags; a new event wins over a clear in the same cycle.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            err_seq <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (seq_evt)      err_seq <= 1'b1;
            else if (clr_err) err_seq <= 1'b0;
            if (ovf_evt)      err_ovf <= 1'b1;
            else if (clr_err) err_ovf <= 1'b0;
        end
    end

    // Issue FSM state register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Issue FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if ((cnt != '0) && w) next_state = LOAD;
            LOAD:    next_state = START;
            START:   next_state = WAIT_LO;
            WAIT_LO: if (!w) next_state = WAIT_HI;
            WAIT_HI: if (w)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered below.
    always_comb begin
        load_d = (next_state == LOAD);
        s_d    = (next_state == START);
        busy_d = (next_state != IDLE);
    end

    // Registered CPU-facing outputs and completed-instruction counter.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            instr_out <= '0;
            load      <= 1'b0;
            s         <= 1'b0;
            busy      <= 1'b0;
            exec_cnt  <= '0;
        end else begin
            load <= load_d;
            s    <= s_d;
            busy <= busy_d;
            if (load_d)   instr_out <= mem[rd_ptr];
            if (exec_inc) exec_cnt  <= exec_cnt + 8'd1;
        end
    end

    assign fifo_cnt = cnt;

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader.
`timescale 1ns/1ps
module tb_instr_loader;

    logic        CLOCK_50;
    logic        reset_n;
    logic [7:0]  byte_in;
    logic        hi_sel;
    logic        byte_valid;
    logic        clr_err;
    logic        w;
    logic [15:0] instr_out;
    logic        load;
    logic        s;
    logic        busy;
    logic [2:0]  fifo_cnt;
    logic        err_seq;
    logic        err_ovf;
    logic [7:0]  exec_cnt;

    int n_vec;
    int n_err;

    instr_loader dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .byte_in    (byte_in),
        .hi_sel     (hi_sel),
        .byte_valid (byte_valid),
        .clr_err    (clr_err),
        .w          (w),
        .instr_out  (instr_out),
        .load       (load),
        .s          (s),
        .busy       (busy),
        .fifo_cnt   (fifo_cnt),
        .err_seq    (err_seq),
        .err_ovf    (err_ovf),
        .exec_cnt   (exec_cnt)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_byte(input logic hs, input logic [7:0] b);
        byte_valid = 1'b1;
        hi_sel     = hs;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
        hi_sel     = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic send_word(input logic [15:0] wd);
        send_byte(1'b1, wd[15:8]);
        send_byte(1'b0, wd[7:0]);
    endtask

    // drive w high and wait (bounded) for the load pulse
    task automatic wait_load(output bit got);
        got = 1'b0;
        w   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (load) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // from the LOAD cycle, walk START -> WAIT_LO -> WAIT_HI -> IDLE
    task automatic finish_handshake();
        w = 1'b0;
        tick();
        tick();
        tick();
        w = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; byte_in = 8'h00; hi_sel = 1'b0; byte_valid = 1'b0;
        clr_err = 1'b0; w = 1'b0;
        tick();
        n_vec++;
        if ({instr_out, load, s, busy, fifo_cnt, err_seq, err_ovf, exec_cnt} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: outputs=%h required=0",
                     {instr_out, load, s, busy, fifo_cnt, err_seq, err_ovf, exec_cnt});
        end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_issue();
        send_word(16'hD020);
        n_vec++;
        if (fifo_cnt !== 3'd1) begin n_err++; $display("FAIL basic_push_cnt: got %0d want 1", fifo_cnt); end
        w = 1'b1;
        tick();
        n_vec++;
        if (load !== 1'b1 || instr_out !== 16'hD020 || s !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_load: load=%b instr=%h s=%b busy=%b want 1 d020 0 1", load, instr_out, s, busy);
        end
        tick();
        n_vec++;
        if (s !== 1'b1 || load !== 1'b0 || fifo_cnt !== 3'd0 || instr_out !== 16'hD020) begin
            n_err++;
            $display("FAIL basic_start: s=%b load=%b cnt=%0d instr=%h want 1 0 0 d020", s, load, fifo_cnt, instr_out);
        end
    endtask

    task automatic test_wait_handshake();
        int bad;
        bad = 0;
        w = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy !== 1'b1 || s !== 1'b0 || load !== 1'b0 || exec_cnt !== 8'd0) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL wait_busy: %0d bad cycles want 0", bad); end
        w = 1'b1;
        tick();
        n_vec++;
        if (exec_cnt !== 8'd1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_done: exec=%0d busy=%b want 1 0", exec_cnt, busy);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0 || load !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b load=%b want 0 0", busy, load);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] words [5];
        bit got;
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        words[3] = 16'h4444; words[4] = 16'h5555;
        w = 1'b0;
        for (int i = 0; i < 4; i++) send_word(words[i]);
        n_vec++;
        if (fifo_cnt !== 3'd4 || err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_full: cnt=%0d ovf=%b want 4 0", fifo_cnt, err_ovf);
        end
        send_word(words[4]);
        n_vec++;
        if (fifo_cnt !== 3'd4 || err_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drop: cnt=%0d ovf=%b want 4 1", fifo_cnt, err_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            wait_load(got);
            n_vec++;
            if (!got || instr_out !== words[i]) begin
                n_err++;
                $display("FAIL ovf_order%0d: load=%b instr=%h want 1 %h", i, got, instr_out, words[i]);
            end
            finish_handshake();
        end
        n_vec++;
        if (fifo_cnt !== 3'd0 || exec_cnt !== 8'd5) begin
            n_err++;
            $display("FAIL ovf_drain: cnt=%0d exec=%0d want 0 5", fifo_cnt, exec_cnt);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_vec++;
        if (err_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: ovf=%b want 0", err_ovf); end
    endtask

    task automatic test_seq_err();
        bit got;
        w = 1'b0;
        send_byte(1'b0, 8'h55);
        n_vec++;
        if (err_seq !== 1'b1 || fifo_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL seq_set: seq=%b cnt=%0d want 1 0", err_seq, fifo_cnt);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_vec++;
        if (err_seq !== 1'b0) begin n_err++; $display("FAIL seq_clear: seq=%b want 0", err_seq); end
        // a second high byte replaces the first without error
        send_byte(1'b1, 8'hAA);
        send_byte(1'b1, 8'hBB);
        send_byte(1'b0, 8'hCC);
        n_vec++;
        if (fifo_cnt !== 3'd1 || err_seq !== 1'b0) begin
            n_err++;
            $display("FAIL hi_overwrite_push: cnt=%0d seq=%b want 1 0", fifo_cnt, err_seq);
        end
        wait_load(got);
        n_vec++;
        if (!got || instr_out !== 16'hBBCC) begin
            n_err++;
            $display("FAIL hi_overwrite_word: load=%b instr=%h want 1 bbcc", got, instr_out);
        end
        finish_handshake();
    endtask

    task automatic test_push_pop_full();
        logic [15:0] exp [4];
        bit got;
        exp[0] = 16'hA002; exp[1] = 16'hA003; exp[2] = 16'hA004; exp[3] = 16'hA005;
        w = 1'b0;
        send_word(16'hA001);
        for (int i = 0; i < 3; i++) send_word(exp[i]);
        send_byte(1'b1, 8'hA0);
        w = 1'b1;
        tick();
        n_vec++;
        if (load !== 1'b1 || instr_out !== 16'hA001 || fifo_cnt !== 3'd4) begin
            n_err++;
            $display("FAIL pp_load: load=%b instr=%h cnt=%0d want 1 a001 4", load, instr_out, fifo_cnt);
        end
        w = 1'b0;
        send_byte(1'b0, 8'h05);
        n_vec++;
        if (fifo_cnt !== 3'd4 || err_ovf !== 1'b0 || s !== 1'b1) begin
            n_err++;
            $display("FAIL pp_same_cycle: cnt=%0d ovf=%b s=%b want 4 0 1", fifo_cnt, err_ovf, s);
        end
        tick();
        tick();
        w = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            wait_load(got);
            n_vec++;
            if (!got || instr_out !== exp[i]) begin
                n_err++;
                $display("FAIL pp_order%0d: load=%b instr=%h want 1 %h", i, got, instr_out, exp[i]);
            end
            finish_handshake();
        end
        n_vec++;
        if (fifo_cnt !== 3'd0 || exec_cnt !== 8'd11) begin
            n_err++;
            $display("FAIL pp_drain: cnt=%0d exec=%0d want 0 11", fifo_cnt, exec_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int loads;
        w = 1'b0;
        send_word(16'h0101);
        send_word(16'h0202);
        send_word(16'h0303);
        wait_load(got);
        w = 1'b0;
        tick();
        tick();
        tick();
        n_vec++;
        if (!got || busy !== 1'b1 || fifo_cnt !== 3'd2 || instr_out !== 16'h0101) begin
            n_err++;
            $display("FAIL rst_pre: load=%b busy=%b cnt=%0d instr=%h want 1 1 2 0101", got, busy, fifo_cnt, instr_out);
        end
        #4;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({instr_out, load, s, busy, fifo_cnt, err_seq, err_ovf, exec_cnt} !== 32'h0) begin
            n_err++;
            $display("FAIL rst_async: outputs=%h required=0",
                     {instr_out, load, s, busy, fifo_cnt, err_seq, err_ovf, exec_cnt});
        end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        w = 1'b1;
        loads = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (load !== 1'b0 || busy !== 1'b0 || fifo_cnt !== 3'd0) loads++;
        end
        n_vec++;
        if (loads != 0) begin n_err++; $display("FAIL rst_flush: %0d bad cycles want 0", loads); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_issue();
        test_wait_handshake();
        test_overflow();
        test_seq_err();
        test_push_pop_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
